// File: rtl/ats_eligibility_time_scheduler.sv
// rtl/ats_eligibility_time_scheduler.sv - per-stream ATS token-bucket eligibility time scheduler
// Collects byte-serial length/timestamp, computes eligibility time and discard, updates bucket state.
module ats_eligibility_time_scheduler #(
  parameter int DATA_WIDTH         = 8,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int TIMESTAMP_WIDTH    = 72,
  parameter int RATE_WIDTH         = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [RATE_WIDTH-1:0]      cfg_ps_per_byte,
  input  logic [TIMESTAMP_WIDTH-1:0] cfg_empty_to_full_ps,
  input  logic [TIMESTAMP_WIDTH-1:0] cfg_max_residence_ps,
  input  logic                       cfg_clear,
  input  logic [DATA_WIDTH-1:0]      s_axis_frame_length_tdata,
  input  logic                       s_axis_frame_length_tvalid,
  output logic                       s_axis_frame_length_tready,
  input  logic                       s_axis_frame_length_tlast,
  input  logic [DATA_WIDTH-1:0]      s_axis_timestamp_tdata,
  input  logic                       s_axis_timestamp_tvalid,
  output logic                       s_axis_timestamp_tready,
  input  logic                       s_axis_timestamp_tlast,
  output logic [TIMESTAMP_WIDTH-1:0] m_axis_eligibility_tdata,
  output logic                       m_axis_eligibility_tuser,
  output logic                       m_axis_eligibility_tvalid,
  input  logic                       m_axis_eligibility_tready,
  output logic [31:0]                passed_count,
  output logic [31:0]                discard_count
);

  localparam int LW = FRAME_LENGTH_WIDTH;
  localparam int TW = TIMESTAMP_WIDTH;
  localparam int EW = TIMESTAMP_WIDTH + 1;
  localparam int MW = FRAME_LENGTH_WIDTH + RATE_WIDTH;

  typedef enum logic [1:0] {COLLECT, MUL, ELIG, OUT} state_t;

  state_t                state;
  logic [LW-1:0]         len_sr;
  logic [TW-1:0]         ts_sr;
  logic                  len_done;
  logic                  ts_done;
  logic [RATE_WIDTH-1:0] ps_per_byte_q;
  logic [TW-1:0]         empty_to_full_q;
  logic [TW-1:0]         max_residence_q;
  logic [TW-1:0]         bucket_empty;
  logic [TW-1:0]         group_elig;
  logic [EW-1:0]         sched_elig;
  logic [EW-1:0]         bucket_full;
  logic                  clear_pending;

  logic          len_acc;
  logic          ts_acc;
  logic          len_complete;
  logic          ts_complete;
  logic          do_clear;
  logic [MW-1:0] len_rec;
  logic [EW-1:0] sched_c;
  logic [EW-1:0] full_c;
  logic [EW-1:0] arrival_x;
  logic [EW-1:0] group_x;
  logic [EW-1:0] max_ag;
  logic [EW-1:0] elig_c;
  logic [EW-1:0] limit_c;
  logic          pass_c;
  logic [EW-1:0] refill_c;
  logic [TW-1:0] new_bucket;

  // Ready is gated by rstn so it drops for exactly the reset period.
  assign s_axis_frame_length_tready = rstn & (state == COLLECT) & ~len_done;
  assign s_axis_timestamp_tready    = rstn & (state == COLLECT) & ~ts_done;

  assign len_acc      = s_axis_frame_length_tvalid & s_axis_frame_length_tready;
  assign ts_acc       = s_axis_timestamp_tvalid & s_axis_timestamp_tready;
  assign len_complete = len_done | (len_acc & s_axis_frame_length_tlast);
  assign ts_complete  = ts_done | (ts_acc & s_axis_timestamp_tlast);
  assign do_clear     = (state == COLLECT) & (cfg_clear | clear_pending);

  assign len_rec = {{RATE_WIDTH{1'b0}}, len_sr} * {{LW{1'b0}}, ps_per_byte_q};
  assign sched_c = {1'b0, bucket_empty} + {{(EW-MW){1'b0}}, len_rec};
  assign full_c  = {1'b0, bucket_empty} + {1'b0, empty_to_full_q};

  // All ELIG arithmetic is one bit wider than a timestamp so compares never wrap.
  assign arrival_x  = {1'b0, ts_sr};
  assign group_x    = {1'b0, group_elig};
  assign max_ag     = (arrival_x > group_x) ? arrival_x : group_x;
  assign elig_c     = (max_ag > sched_elig) ? max_ag : sched_elig;
  assign limit_c    = arrival_x + {1'b0, max_residence_q};
  assign pass_c     = (elig_c <= limit_c);
  assign refill_c   = sched_elig + elig_c - bucket_full;
  assign new_bucket = (elig_c < bucket_full) ? sched_elig[TW-1:0] : refill_c[TW-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                     <= COLLECT;
      len_sr                    <= '0;
      ts_sr                     <= '0;
      len_done                  <= 1'b0;
      ts_done                   <= 1'b0;
      ps_per_byte_q             <= '0;
      empty_to_full_q           <= '0;
      max_residence_q           <= '0;
      bucket_empty              <= '0;
      group_elig                <= '0;
      sched_elig                <= '0;
      bucket_full               <= '0;
      clear_pending             <= 1'b0;
      m_axis_eligibility_tdata  <= '0;
      m_axis_eligibility_tuser  <= 1'b0;
      m_axis_eligibility_tvalid <= 1'b0;
      passed_count              <= '0;
      discard_count             <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (len_acc) len_sr <= {len_sr[LW-DATA_WIDTH-1:0], s_axis_frame_length_tdata};
          if (ts_acc)  ts_sr  <= {ts_sr[TW-DATA_WIDTH-1:0], s_axis_timestamp_tdata};
          if (len_complete && ts_complete) begin
            len_done        <= 1'b0;
            ts_done         <= 1'b0;
            ps_per_byte_q   <= cfg_ps_per_byte;
            empty_to_full_q <= cfg_empty_to_full_ps;
            max_residence_q <= cfg_max_residence_ps;
            state           <= MUL;
          end else begin
            len_done <= len_complete;
            ts_done  <= ts_complete;
          end
        end
        MUL: begin
          sched_elig  <= sched_c;
          bucket_full <= full_c;
          state       <= ELIG;
        end
        ELIG: begin
          m_axis_eligibility_tdata  <= elig_c[TW-1:0];
          m_axis_eligibility_tuser  <= ~pass_c;
          m_axis_eligibility_tvalid <= 1'b1;
          if (pass_c) begin
            group_elig   <= elig_c[TW-1:0];
            bucket_empty <= new_bucket;
            if (passed_count != '1) passed_count <= passed_count + 32'd1;
          end else begin
            if (discard_count != '1) discard_count <= discard_count + 32'd1;
          end
          state <= OUT;
        end
        OUT: begin
          if (m_axis_eligibility_tready) begin
            m_axis_eligibility_tvalid <= 1'b0;
            len_sr                    <= '0;
            ts_sr                     <= '0;
            state                     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase

      // Clear wins over any update on the same edge; outside COLLECT it waits.
      if (do_clear) begin
        bucket_empty  <= '0;
        group_elig    <= '0;
        passed_count  <= '0;
        discard_count <= '0;
        clear_pending <= 1'b0;
      end else if (cfg_clear) begin
        clear_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ats_eligibility_time_scheduler.sv
// tb/tb_ats_eligibility_time_scheduler.sv - directed self-checking bench for ats_eligibility_time_scheduler
module tb_ats_eligibility_time_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] cfg_ps_per_byte;
  logic [71:0] cfg_empty_to_full_ps;
  logic [71:0] cfg_max_residence_ps;
  logic        cfg_clear;
  logic [7:0]  l_tdata;
  logic        l_tvalid;
  logic        l_tready;
  logic        l_tlast;
  logic [7:0]  t_tdata;
  logic        t_tvalid;
  logic        t_tready;
  logic        t_tlast;
  logic [71:0] e_tdata;
  logic        e_tuser;
  logic        e_tvalid;
  logic        e_tready;
  logic [31:0] passed_count;
  logic [31:0] discard_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ats_eligibility_time_scheduler dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .cfg_ps_per_byte            (cfg_ps_per_byte),
    .cfg_empty_to_full_ps       (cfg_empty_to_full_ps),
    .cfg_max_residence_ps       (cfg_max_residence_ps),
    .cfg_clear                  (cfg_clear),
    .s_axis_frame_length_tdata  (l_tdata),
    .s_axis_frame_length_tvalid (l_tvalid),
    .s_axis_frame_length_tready (l_tready),
    .s_axis_frame_length_tlast  (l_tlast),
    .s_axis_timestamp_tdata     (t_tdata),
    .s_axis_timestamp_tvalid    (t_tvalid),
    .s_axis_timestamp_tready    (t_tready),
    .s_axis_timestamp_tlast     (t_tlast),
    .m_axis_eligibility_tdata   (e_tdata),
    .m_axis_eligibility_tuser   (e_tuser),
    .m_axis_eligibility_tvalid  (e_tvalid),
    .m_axis_eligibility_tready  (e_tready),
    .passed_count               (passed_count),
    .discard_count              (discard_count)
  );

  task automatic check(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [71:0] ts,
                            input int len_delay, input int ts_delay);
    int li;
    int ti;
    int cyc;
    logic la;
    logic ta;
    li = 0; ti = 0; cyc = 0;
    while ((li < 2 || ti < 9) && cyc < 300) begin
      @(negedge clk);
      l_tvalid = (cyc >= len_delay) && (li < 2);
      l_tdata  = (li < 2) ? len[8*(1-li) +: 8] : 8'h00;
      l_tlast  = (li == 1);
      t_tvalid = (cyc >= ts_delay) && (ti < 9);
      t_tdata  = (ti < 9) ? ts[8*(8-ti) +: 8] : 8'h00;
      t_tlast  = (ti == 8);
      #1;
      la = l_tvalid && l_tready;
      ta = t_tvalid && t_tready;
      @(posedge clk);
      if (la) li++;
      if (ta) ti++;
      cyc++;
    end
    check("stream_accepted", 72'((li == 2) && (ti == 9)), 72'd1);
  endtask

  task automatic get_result(input string tag, input logic [71:0] exp_elig, input logic exp_user,
                            input int hold, input int clear_at, input logic [31:0] exp_passed_hold);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      l_tvalid = 1'b0; t_tvalid = 1'b0; l_tlast = 1'b0; t_tlast = 1'b0;
      n++;
    end while (!e_tvalid && n < 20);
    check({tag, "_latency"}, 72'(n), 72'd3);
    check({tag, "_elig"}, e_tdata, exp_elig);
    check({tag, "_tuser"}, 72'(e_tuser), 72'(exp_user));
    for (int i = 0; i < hold; i++) begin
      l_tvalid = 1'b1; t_tvalid = 1'b1; l_tdata = 8'hA5; t_tdata = 8'h5A;
      cfg_clear = (i == clear_at);
      #1;
      check({tag, "_hold_len_tready"}, 72'(l_tready), 72'd0);
      check({tag, "_hold_ts_tready"}, 72'(t_tready), 72'd0);
      @(negedge clk);
      check({tag, "_hold_tvalid"}, 72'(e_tvalid), 72'd1);
      check({tag, "_hold_elig"}, e_tdata, exp_elig);
      check({tag, "_hold_tuser"}, 72'(e_tuser), 72'(exp_user));
    end
    cfg_clear = 1'b0; l_tvalid = 1'b0; t_tvalid = 1'b0;
    if (hold > 0) check({tag, "_deferred_clear_passed"}, 72'(passed_count), 72'(exp_passed_hold));
    e_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e_tready = 1'b0;
    check({tag, "_tvalid_drop"}, 72'(e_tvalid), 72'd0);
  endtask

  initial begin
    rstn = 1'b0;
    cfg_ps_per_byte = 32'd8000;
    cfg_empty_to_full_ps = 72'd12_000_000;
    cfg_max_residence_ps = 72'd20_000_000;
    cfg_clear = 1'b0;
    l_tdata = '0; l_tvalid = 1'b0; l_tlast = 1'b0;
    t_tdata = '0; t_tvalid = 1'b0; t_tlast = 1'b0;
    e_tready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_len_tready", 72'(l_tready), 72'd0);
    check("rst_ts_tready", 72'(t_tready), 72'd0);
    check("rst_tvalid", 72'(e_tvalid), 72'd0);
    check("rst_tdata", e_tdata, 72'd0);
    check("rst_passed", 72'(passed_count), 72'd0);
    check("rst_discard", 72'(discard_count), 72'd0);
    rstn = 1'b1;
    #1;
    check("post_rst_len_tready", 72'(l_tready), 72'd1);
    check("post_rst_ts_tready", 72'(t_tready), 72'd1);

    // 1: first frame, bucket empty
    send_frame(16'd100, 72'd1_000_000, 0, 0);
    get_result("t1", 72'd1_000_000, 1'b0, 0, -1, 32'd0);
    check("t1_bucket", dut.bucket_empty, 72'd800_000);
    check("t1_passed", 72'(passed_count), 72'd1);

    // 3: too little residence budget -> discard, state unchanged
    cfg_max_residence_ps = 72'd1_000_000;
    send_frame(16'd1500, 72'd1_000_008, 0, 0);
    get_result("t3", 72'd12_800_000, 1'b1, 0, -1, 32'd0);
    check("t3_discard", 72'(discard_count), 72'd1);
    check("t3_bucket", dut.bucket_empty, 72'd800_000);
    check("t3_group", dut.group_elig, 72'd1_000_000);
    check("t3_passed", 72'(passed_count), 72'd1);

    // 2: same frame with normal residence -> bucket at exactly full
    cfg_max_residence_ps = 72'd20_000_000;
    send_frame(16'd1500, 72'd1_000_008, 0, 0);
    get_result("t2", 72'd12_800_000, 1'b0, 0, -1, 32'd0);
    check("t2_bucket", dut.bucket_empty, 72'd12_800_000);
    check("t2_passed", 72'(passed_count), 72'd2);

    // Clear in COLLECT takes effect on the next edge
    @(negedge clk); cfg_clear = 1'b1;
    @(negedge clk); cfg_clear = 1'b0;
    check("clr_bucket", dut.bucket_empty, 72'd0);
    check("clr_group", dut.group_elig, 72'd0);
    check("clr_passed", 72'(passed_count), 72'd0);
    check("clr_discard", 72'(discard_count), 72'd0);

    // 4: late arrival refills the bucket
    send_frame(16'd100, 72'd1_000_000, 0, 0);
    get_result("t4a", 72'd1_000_000, 1'b0, 0, -1, 32'd0);
    send_frame(16'd100, 72'd100_000_000, 0, 0);
    get_result("t4", 72'd100_000_000, 1'b0, 0, -1, 32'd0);
    check("t4_bucket", dut.bucket_empty, 72'd88_800_000);

    // 5: 30-cycle skew, output back-pressured 10 cycles, clear pulsed while in OUT
    send_frame(16'd100, 72'd100_000_100, 30, 0);
    get_result("t5", 72'd100_000_100, 1'b0, 10, 2, 32'd3);
    @(negedge clk);
    check("t6_clear_passed", 72'(passed_count), 72'd0);
    check("t6_clear_discard", 72'(discard_count), 72'd0);
    check("t6_clear_bucket", dut.bucket_empty, 72'd0);
    check("t6_clear_group", dut.group_elig, 72'd0);

    // 6: reset mid-stream discards partial bytes
    l_tvalid = 1'b1; l_tdata = 8'h05; l_tlast = 1'b0;
    t_tvalid = 1'b1; t_tdata = 8'h77; t_tlast = 1'b0;
    @(negedge clk);
    rstn = 1'b0; l_tvalid = 1'b0; t_tvalid = 1'b0;
    #1;
    check("t6_rst_len_tready", 72'(l_tready), 72'd0);
    check("t6_rst_ts_tready", 72'(t_tready), 72'd0);
    @(negedge clk);
    rstn = 1'b1;
    send_frame(16'd100, 72'd1_000_000, 0, 0);
    get_result("t6", 72'd1_000_000, 1'b0, 0, -1, 32'd0);
    check("t6_bucket", dut.bucket_empty, 72'd800_000);
    check("t6_passed", 72'(passed_count), 72'd1);
    check("t6_discard", 72'(discard_count), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
